// File: rtl/fifo_pkg.sv
// Shared constants, pointer layout and occupancy helper for the FIFO controller.
package fifo_pkg;

    localparam int DEFAULT_ADDR_W   = 3;
    localparam int DEFAULT_AE_LEVEL = 1;

    // Pointer layout for the default depth: wrap bit above the RAM address.
    typedef struct packed {
        logic                      wrap;
        logic [DEFAULT_ADDR_W-1:0] addr;
    } ptr_t;

    function automatic logic [31:0] ptr_count(input logic [31:0] wptr,
                                              input logic [31:0] rptr,
                                              input int          addr_w);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// Request/status bundle between a FIFO client (master) and the controller (slave).
interface fifo_ctrl_param_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              wr_en;
    logic              rd_en;
    logic              flush;
    logic              err_clr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              wen;
    logic              ren;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, rd_en, flush, err_clr,
        input  waddr, raddr, wen, ren, rd_valid, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, flush, err_clr,
        output waddr, raddr, wen, ren, rd_valid, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with synchronous reset, clear and increment enable.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);
    always_ff @(posedge clk) begin
        if (reset || clear)
            value <= '0;
        else if (inc)
            value <= value + W'(1);
    end
endmodule

// File: rtl/fifo_ctrl_param.sv
// Pointer/flag controller for a single-clock FIFO around an external synchronous dual-port RAM.
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int AF_LEVEL = 2**ADDR_W - 1,
    parameter int AE_LEVEL = DEFAULT_AE_LEVEL
) (
    input logic               clk,
    input logic               reset,
    fifo_ctrl_param_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR = PW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_check
        $error("fifo_ctrl_param: AF_LEVEL must be within 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_ae_check
        $error("fifo_ctrl_param: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] count;
    logic            full;
    logic            empty;
    logic            wen;
    logic            ren;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count = PW'(ptr_count(32'(wptr), 32'(rptr), ADDR_W));

    // Flags are judged on the pre-edge pointers, so a full FIFO never passes a write through.
    assign wen = bus.wr_en && !full  && !bus.flush && !reset;
    assign ren = bus.rd_en && !empty && !bus.flush && !reset;

    fifo_ptr #(.W(PW)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .inc   (wen),
        .value (wptr)
    );

    fifo_ptr #(.W(PW)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .inc   (ren),
        .value (rptr)
    );

    assign bus.waddr        = wptr[ADDR_W-1:0];
    assign bus.raddr        = rptr[ADDR_W-1:0];
    assign bus.wen          = wen;
    assign bus.ren          = ren;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_THR);
    assign bus.almost_empty = (count <= AE_THR);

    // Error flags survive a flush; a fresh error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_valid  <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.rd_valid  <= bus.flush ? 1'b0 : ren;
            bus.overflow  <= (bus.wr_en && full)  || (bus.overflow  && !bus.err_clr);
            bus.underflow <= (bus.rd_en && empty) || (bus.underflow && !bus.err_clr);
        end
    end
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param: fixed vector table, directed corner sequences, random traffic vs. an occupancy model.
module tb_fifo_ctrl_param;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF     = 7;
    localparam int AE     = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_ctrl_param_if #(.ADDR_W(ADDR_W)) bus();

    fifo_ctrl_param #(
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wen, ren, rdv, full, empty, af, ae, ovf, unf;
        logic [3:0] count;
        logic [2:0] waddr, raddr;
    } obs_t;

    typedef struct packed {
        logic rst, wr, rd, fl, ec;
        obs_t exp;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: occupancy plus unbounded write/read totals.
    int m_occ, m_wtot, m_rtot;
    bit m_ovf, m_unf, m_rv;

    vec_t tbl [23];

    function automatic obs_t mk(logic wen, logic ren, logic rdv, logic full, logic empty,
                                logic af, logic ae, logic ovf, logic unf,
                                int cnt, int wa, int ra);
        obs_t o;
        o.wen = wen; o.ren = ren; o.rdv = rdv; o.full = full; o.empty = empty;
        o.af = af; o.ae = ae; o.ovf = ovf; o.unf = unf;
        o.count = 4'(cnt); o.waddr = 3'(wa); o.raddr = 3'(ra);
        return o;
    endfunction

    function automatic vec_t row(logic rst, logic wr, logic rd, logic fl, logic ec, obs_t e);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec; v.exp = e;
        return v;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.wen = bus.wen; o.ren = bus.ren; o.rdv = bus.rd_valid;
        o.full = bus.full; o.empty = bus.empty;
        o.af = bus.almost_full; o.ae = bus.almost_empty;
        o.ovf = bus.overflow; o.unf = bus.underflow;
        o.count = bus.count; o.waddr = bus.waddr; o.raddr = bus.raddr;
        return o;
    endfunction

    function automatic obs_t model_expect(logic rst, logic wr, logic rd, logic fl);
        obs_t o;
        o.wen   = !rst && wr && (m_occ < DEPTH) && !fl;
        o.ren   = !rst && rd && (m_occ > 0) && !fl;
        o.rdv   = m_rv;
        o.full  = (m_occ == DEPTH);
        o.empty = (m_occ == 0);
        o.af    = (m_occ >= AF);
        o.ae    = (m_occ <= AE);
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        o.count = 4'(m_occ);
        o.waddr = 3'(m_wtot % DEPTH);
        o.raddr = 3'(m_rtot % DEPTH);
        return o;
    endfunction

    task automatic model_update(input logic rst, input logic wr, input logic rd,
                                input logic fl, input logic ec);
        bit w_ok, r_ok, new_ovf, new_unf;
        w_ok    = wr && (m_occ < DEPTH) && !fl;
        r_ok    = rd && (m_occ > 0) && !fl;
        new_ovf = wr && (m_occ == DEPTH);
        new_unf = rd && (m_occ == 0);
        if (rst) begin
            m_occ = 0; m_wtot = 0; m_rtot = 0;
            m_ovf = 0; m_unf = 0; m_rv = 0;
        end else begin
            m_ovf = new_ovf || (m_ovf && !ec);
            m_unf = new_unf || (m_unf && !ec);
            if (fl) begin
                m_occ = 0; m_wtot = 0; m_rtot = 0; m_rv = 0;
            end else begin
                m_occ  = m_occ + int'(w_ok) - int'(r_ok);
                m_wtot = m_wtot + int'(w_ok);
                m_rtot = m_rtot + int'(r_ok);
                m_rv   = r_ok;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                                 input logic fl, input logic ec);
        @(negedge clk);
        reset       = rst;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.flush   = fl;
        bus.err_clr = ec;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic wr, input logic rd,
                        input logic fl, input logic ec);
        applyStimulus(rst, wr, rd, fl, ec);
        checkOutput(name, 32'(observe()), 32'(model_expect(rst, wr, rd, fl)));
        model_update(rst, wr, rd, fl, ec);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;

        // Reset-with-write, fill past full, drain past empty, then clear the errors.
        tbl[0]  = row(1,1,0,0,0, mk(0,0,0,0,1,0,1,0,0, 0,0,0));
        tbl[1]  = row(0,1,0,0,0, mk(1,0,0,0,1,0,1,0,0, 0,0,0));
        tbl[2]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,1,0,0, 1,1,0));
        tbl[3]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,0,0,0, 2,2,0));
        tbl[4]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,0,0,0, 3,3,0));
        tbl[5]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,0,0,0, 4,4,0));
        tbl[6]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,0,0,0, 5,5,0));
        tbl[7]  = row(0,1,0,0,0, mk(1,0,0,0,0,0,0,0,0, 6,6,0));
        tbl[8]  = row(0,1,0,0,0, mk(1,0,0,0,0,1,0,0,0, 7,7,0));
        tbl[9]  = row(0,1,0,0,0, mk(0,0,0,1,0,1,0,0,0, 8,0,0));
        tbl[10] = row(0,1,0,0,0, mk(0,0,0,1,0,1,0,1,0, 8,0,0));
        tbl[11] = row(0,0,1,0,0, mk(0,1,0,1,0,1,0,1,0, 8,0,0));
        tbl[12] = row(0,0,1,0,0, mk(0,1,1,0,0,1,0,1,0, 7,0,1));
        tbl[13] = row(0,0,1,0,0, mk(0,1,1,0,0,0,0,1,0, 6,0,2));
        tbl[14] = row(0,0,1,0,0, mk(0,1,1,0,0,0,0,1,0, 5,0,3));
        tbl[15] = row(0,0,1,0,0, mk(0,1,1,0,0,0,0,1,0, 4,0,4));
        tbl[16] = row(0,0,1,0,0, mk(0,1,1,0,0,0,0,1,0, 3,0,5));
        tbl[17] = row(0,0,1,0,0, mk(0,1,1,0,0,0,0,1,0, 2,0,6));
        tbl[18] = row(0,0,1,0,0, mk(0,1,1,0,0,0,1,1,0, 1,0,7));
        tbl[19] = row(0,0,1,0,0, mk(0,0,1,0,1,0,1,1,0, 0,0,0));
        tbl[20] = row(0,0,1,0,0, mk(0,0,0,0,1,0,1,1,1, 0,0,0));
        tbl[21] = row(0,0,0,0,1, mk(0,0,0,0,1,0,1,1,1, 0,0,0));
        tbl[22] = row(0,0,0,0,0, mk(0,0,0,0,1,0,1,0,0, 0,0,0));

        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 23; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].ec);
            checkOutput($sformatf("table[%0d]", i), 32'(observe()), 32'(tbl[i].exp));
        end

        m_occ = 0; m_wtot = 8; m_rtot = 8; m_ovf = 0; m_unf = 0; m_rv = 0;

        // Concurrent read+write at mid occupancy keeps the count.
        for (int i = 0; i < 4; i++) step("conc_fill", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("conc_rw", 0, 1, 1, 0, 0);
        step("conc_idle", 0, 0, 0, 0, 0);
        checkOutput("conc_count4", 32'(bus.count), 32'd4);

        // Both requests while full: read wins, write is rejected.
        for (int i = 0; i < 4; i++) step("full_fill", 0, 1, 0, 0, 0);
        step("full_both", 0, 1, 1, 0, 0);
        checkOutput("full_both_wen_ren", {30'd0, bus.wen, bus.ren}, 32'b01);
        step("full_after", 0, 0, 0, 0, 0);
        checkOutput("full_after_count_ovf", {27'd0, bus.count, bus.overflow}, {27'd0, 4'd7, 1'b1});

        // Both requests while empty: write wins, read is rejected.
        for (int i = 0; i < 7; i++) step("drain", 0, 0, 1, 0, 0);
        step("empty_both", 0, 1, 1, 0, 0);
        checkOutput("empty_both_wen_ren", {30'd0, bus.wen, bus.ren}, 32'b10);
        step("empty_after", 0, 0, 0, 0, 0);
        checkOutput("empty_after_count_unf", {27'd0, bus.count, bus.underflow}, {27'd0, 4'd1, 1'b1});
        step("err_clr", 0, 0, 0, 0, 1);
        step("last_read", 0, 0, 1, 0, 0);

        // Interleaved write/read pairs walk the pointers through their wrap.
        for (int i = 0; i < 20; i++) begin
            step("wrap_wr", 0, 1, 0, 0, 0);
            step("wrap_rd", 0, 0, 1, 0, 0);
        end

        // Flush at count 5 with a pending write and a sticky overflow.
        for (int i = 0; i < 9; i++) step("flush_fill", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("flush_rd", 0, 0, 1, 0, 0);
        step("flush_cycle", 0, 1, 0, 1, 0);
        checkOutput("flush_wen", {31'd0, bus.wen}, 32'd0);
        step("flush_after", 0, 0, 0, 0, 0);
        checkOutput("flush_after_cnt_empty_ovf",
                    {26'd0, bus.count, bus.empty, bus.overflow}, {26'd0, 4'd0, 1'b1, 1'b1});

        for (int i = 0; i < 3000; i++) begin
            int   bias;
            logic wr, rd, fl, ec, rst;
            bias = ((i / 250) % 2 == 1) ? 30 : 70;
            wr  = ($urandom_range(0, 99) < bias);
            rd  = ($urandom_range(0, 99) < (100 - bias));
            fl  = ($urandom_range(0, 99) < 2);
            ec  = ($urandom_range(0, 99) < 5);
            rst = ($urandom_range(0, 999) < 5);
            step($sformatf("random[%0d]", i), rst, wr, rd, fl, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised pointer/flag controller for a single-clock FIFO built around an external simple dual-port RAM. It is used in the sparse-matrix datapath to buffer row/column/value streams between stages. It supersedes the fixed 8-entry read-or-write controller with the following features:
- independent read and write enables, with same-cycle read+write;
- occupancy count and almost-full/almost-empty thresholds;
- sticky overflow/underflow flags;
- synchronous flush;
- a read-data-valid strobe that matches synchronous RAM latency.

Parameters:
ADDR_W, 3, RAM address width; depth DEPTH = 2**ADDR_W entries.
AF_LEVEL, 2**ADDR_W-1, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request this cycle
rd_en  in  1  read request this cycle
flush  in  1  synchronous pointer clear
err_clr  in  1  clears sticky error flags
waddr  out  ADDR_W  RAM write address (valid when wen=1)
raddr  out  ADDR_W  RAM read address (valid when ren=1)
wen  out  1  accepted write; drives RAM write enable
ren  out  1  accepted read; drives RAM read enable
rd_valid  out  1  RAM read data valid (1 cycle after ren)
count  out  ADDR_W+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow  out  1  sticky: write requested while full
underflow  out  1  sticky: read requested while empty

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high.
- Pointers: internal wptr and rptr, each ADDR_W+1 bits with a wrap bit.
  - waddr = wptr[ADDR_W-1:0]; raddr = rptr[ADDR_W-1:0].
  - count = wptr - rptr, modulo 2**(ADDR_W+1).
  - full = (MSBs differ && low bits equal); empty = (wptr == rptr).
- Flags: all flags are combinational from the registered pointers, so they are valid in the same cycle as the pointers.
- Accept rules, combinational, same cycle:
  - wen = wr_en && !full && !flush.
  - ren = rd_en && !empty && !flush.
- Pointer update on the clock edge:
  - wptr += 1 if wen; rptr += 1 if ren.
  - Natural wrap from 2**(ADDR_W+1)-1 to 0.
- Simultaneous read+write:
  - Both are accepted when neither flag blocks them; count is unchanged.
  - When full, the read is accepted and the write is rejected (full is evaluated before the read, no pass-through).
  - When empty, the write is accepted and the read is rejected (no fall-through).
- rd_valid: register of ren, 1-cycle latency to match synchronous RAM.
- Error flags:
  - overflow set when wr_en && full; underflow set when rd_en && empty.
  - Both hold until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Flush:
  - Next edge: wptr = rptr = 0 and rd_valid = 0.
  - Accepts are suppressed in that cycle, so wen = ren = 0.
  - Error flags are preserved.
- Priority: reset > flush > normal operation.
- Reset value of every output:
  - wptr = rptr = 0, so waddr = raddr = 0, count = 0, empty = 1, full = 0, almost_empty = 1 (AE_LEVEL >= 0).
  - almost_full = 0 (AF_LEVEL > 0); wen = ren = 0 during reset; rd_valid = 0; overflow = underflow = 0.
- Reset mid-operation: reset takes effect at the next edge regardless of wr_en/rd_en. RAM contents are not cleared and are don't-care.
- Elaboration checks: 1 <= AF_LEVEL <= DEPTH; 0 <= AE_LEVEL < DEPTH.

Decomposition:
- Package fifo_pkg holds:
  - a function computing count from two pointers;
  - a typedef for the pointer struct (wrap bit + address);
  - default level constants.
- Sub-module fifo_ptr: (ADDR_W+1)-bit wrapping counter with synchronous reset, clear and increment enable. Instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- Reset, ADDR_W=3: assert reset 2 cycles with wr_en=1 -> waddr=0, count=0, empty=1, almost_empty=1, wen=0.
- Fill: 8 writes -> count 1..8; almost_full at count 7; full at 8; 9th wr_en gives wen=0 and overflow=1; waddr wraps 7 -> 0.
- Drain: 8 reads -> ren on each; rd_valid exactly 1 cycle later; empty at count 0; extra rd_en gives underflow=1. err_clr -> both errors 0.
- Concurrency: at count=4, 5 cycles wr_en=rd_en=1 -> count stays 4. At full, both high -> count 7, overflow=1. At empty, both high -> count 1, underflow=1.
- Wrap: 20 interleaved write/read pairs -> pointers wrap past 15; full/empty stay correct; count never exceeds 8.
- Flush: at count=5 with wr_en=1, assert flush -> wen=0, next cycle count=0 and empty=1; an overflow=1 set earlier is still 1.
